// File: rtl/arbitro_rr_pkg.sv
// Shared definitions for the 4-input / 4-output round-robin arbiter.
package arbitro_rr_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ARB  = 1'b1
    } arb_state_t;

    localparam int N_FIFO = 4;
    localparam int DEST_W = 2;

    // Destination index lives in the top DEST_W bits of every word.
    function automatic int dest_lsb(input int data_w);
        return data_w - DEST_W;
    endfunction

    function automatic logic [N_FIFO-1:0] dest_onehot(input logic [DEST_W-1:0] d);
        logic [N_FIFO-1:0] oh;
        case (d)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/arbitro_rr_if.sv
// FIFO-side and counter-read signals of the arbiter, grouped as one bundle.
interface arbitro_rr_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 5
);
    logic              enable;
    logic [3:0]        empty_F;
    logic [DATA_W-1:0] data_F0;
    logic [DATA_W-1:0] data_F1;
    logic [DATA_W-1:0] data_F2;
    logic [DATA_W-1:0] data_F3;
    logic [3:0]        almost_full_P;
    logic [3:0]        pop_F;
    logic [3:0]        push_P;
    logic [DATA_W-1:0] data_out;
    logic              req;
    logic [1:0]        idx;
    logic              valid_contador;
    logic [CNT_W-1:0]  contador_out;
    logic              arb_idle;

    modport slave (
        input  enable, empty_F, data_F0, data_F1, data_F2, data_F3,
        input  almost_full_P, req, idx,
        output pop_F, push_P, data_out, valid_contador, contador_out, arb_idle
    );

    modport master (
        output enable, empty_F, data_F0, data_F1, data_F2, data_F3,
        output almost_full_P, req, idx,
        input  pop_F, push_P, data_out, valid_contador, contador_out, arb_idle
    );
endinterface

// File: rtl/arbitro_rr_prioridad.sv
// Combinational 4-way round-robin priority select starting the search at i_ptr.
module rr_prioridad
    import arbitro_rr_pkg::*;
(
    input  logic [N_FIFO-1:0] i_eligible,
    input  logic [1:0]        i_ptr,
    output logic [N_FIFO-1:0] o_grant
);

    // Walk ptr, ptr+1, ... (mod 4); the first eligible candidate wins.
    always_comb begin
        logic [1:0] w_cand;
        logic       w_found;
        o_grant = {N_FIFO{1'b0}};
        w_found = 1'b0;
        w_cand  = 2'd0;
        for (int k = 0; k < N_FIFO; k++) begin
            w_cand          = i_ptr + 2'(k);
            o_grant[w_cand] = o_grant[w_cand] | (~w_found & i_eligible[w_cand]);
            w_found         = w_found | i_eligible[w_cand];
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin arbiter moving words from input FIFOs F0..F3 to output FIFOs P4..P7,
// with per-destination transfer counters readable on request.
module arbitro_rr
    import arbitro_rr_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 5
) (
    input  logic         clk,
    input  logic         reset,
    arbitro_rr_if.slave  bus
);

    localparam int DEST_LSB = dest_lsb(DATA_W);

    logic [DATA_W-1:0] w_data [N_FIFO];
    logic [DEST_W-1:0] w_dest [N_FIFO];
    logic [N_FIFO-1:0] w_eligible;
    logic [N_FIFO-1:0] w_grant;
    logic [N_FIFO-1:0] w_pop;
    logic              w_fire;
    logic [1:0]        w_win_idx;
    logic [DEST_W-1:0] w_win_dest;
    logic [DATA_W-1:0] w_win_data;
    logic              w_any_data;

    arb_state_t        r_state;
    logic              r_idle;
    logic [1:0]        r_ptr;
    logic [N_FIFO-1:0] r_push;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt [N_FIFO];
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt_out;

    assign w_data[0]  = bus.data_F0;
    assign w_data[1]  = bus.data_F1;
    assign w_data[2]  = bus.data_F2;
    assign w_data[3]  = bus.data_F3;
    assign w_any_data = ~(&bus.empty_F);

    // A head word is eligible only if its own destination can still take data.
    always_comb begin
        for (int i = 0; i < N_FIFO; i++) begin
            w_dest[i]     = w_data[i][DEST_LSB +: DEST_W];
            w_eligible[i] = ~bus.empty_F[i] & ~bus.almost_full_P[w_dest[i]];
        end
    end

    rr_prioridad u_prioridad (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant)
    );

    always_comb begin
        if (!reset && (r_state == ST_ARB) && bus.enable) begin
            w_pop = w_grant;
        end else begin
            w_pop = {N_FIFO{1'b0}};
        end
    end

    always_comb begin
        w_fire    = |w_pop;
        w_win_idx = 2'd0;
        case (w_pop)
            4'b0001: w_win_idx = 2'd0;
            4'b0010: w_win_idx = 2'd1;
            4'b0100: w_win_idx = 2'd2;
            4'b1000: w_win_idx = 2'd3;
            default: w_win_idx = 2'd0;
        endcase
        w_win_dest = w_dest[w_win_idx];
        w_win_data = w_data[w_win_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idle  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.enable && w_any_data) begin
                        r_state <= ST_ARB;
                        r_idle  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_idle  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (!bus.enable || !w_any_data) begin
                        r_state <= ST_IDLE;
                        r_idle  <= 1'b1;
                    end else begin
                        r_state <= ST_ARB;
                        r_idle  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

    // The popped word is pushed one cycle later; the search restarts after the winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr  <= 2'd0;
            r_push <= {N_FIFO{1'b0}};
            r_data <= {DATA_W{1'b0}};
        end else if (w_fire) begin
            r_ptr  <= w_win_idx + 2'd1;
            r_push <= dest_onehot(w_win_dest);
            r_data <= w_win_data;
        end else begin
            r_ptr  <= r_ptr;
            r_push <= {N_FIFO{1'b0}};
            r_data <= r_data;
        end
    end

    // A read on the counter being incremented sees the value before this push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < N_FIFO; d++) begin
                r_cnt[d] <= {CNT_W{1'b0}};
            end
            r_valid   <= 1'b0;
            r_cnt_out <= {CNT_W{1'b0}};
        end else begin
            for (int d = 0; d < N_FIFO; d++) begin
                if (w_fire && (w_win_dest == 2'(d))) begin
                    r_cnt[d] <= r_cnt[d] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    r_cnt[d] <= r_cnt[d];
                end
            end
            if (bus.req) begin
                r_valid   <= 1'b1;
                r_cnt_out <= r_cnt[bus.idx];
            end else begin
                r_valid   <= 1'b0;
                r_cnt_out <= r_cnt_out;
            end
        end
    end

    assign bus.pop_F          = w_pop;
    assign bus.push_P         = r_push;
    assign bus.data_out       = r_data;
    assign bus.valid_contador = r_valid;
    assign bus.contador_out   = r_cnt_out;
    assign bus.arb_idle       = r_idle;

endmodule

// File: tb/tb_arbitro_rr.sv
// Self-checking bench for arbitro_rr: directed scenarios plus a randomized run
// against a behavioural model of the round-robin and counter rules.
module tb_arbitro_rr;

    localparam int DW = 6;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arbitro_rr_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    arbitro_rr #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [5:0] a, input logic [5:0] b,
                            input logic [5:0] c, input logic [5:0] e);
        bus.data_F0 = a;
        bus.data_F1 = b;
        bus.data_F2 = c;
        bus.data_F3 = e;
    endtask

    task automatic idle_inputs;
        bus.enable        = 1'b0;
        bus.empty_F       = 4'hF;
        bus.almost_full_P = 4'h0;
        bus.req           = 1'b0;
        bus.idx           = 2'd0;
        set_data(6'd0, 6'd0, 6'd0, 6'd0);
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        bus.enable  = 1'b1;
        bus.empty_F = 4'h0;
        set_data(6'h01, 6'h12, 6'h23, 6'h34);
        tick();
        tick();
        n_checks++; if (bus.pop_F !== 4'b0000) begin n_fail++; $display("FAIL rst_pop: got %b exp 0000", bus.pop_F); end
        n_checks++; if (bus.push_P !== 4'b0000) begin n_fail++; $display("FAIL rst_push: got %b exp 0000", bus.push_P); end
        n_checks++; if (bus.data_out !== 6'd0) begin n_fail++; $display("FAIL rst_data: got %h exp 00", bus.data_out); end
        n_checks++; if (bus.valid_contador !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", bus.valid_contador); end
        n_checks++; if (bus.contador_out !== 5'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d exp 0", bus.contador_out); end
        n_checks++; if (bus.arb_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b exp 1", bus.arb_idle); end
        reset = 1'b0;
    endtask

    task automatic test_single;
        do_reset();
        bus.enable  = 1'b1;
        bus.empty_F = 4'b1011;
        set_data(6'd0, 6'd0, 6'b01_1010, 6'd0);
        #1;
        n_checks++; if (bus.pop_F !== 4'b0000) begin n_fail++; $display("FAIL single_idle_pop: got %b exp 0000", bus.pop_F); end
        tick();
        n_checks++; if (bus.pop_F !== 4'b0100) begin n_fail++; $display("FAIL single_pop: got %b exp 0100", bus.pop_F); end
        n_checks++; if (bus.arb_idle !== 1'b0) begin n_fail++; $display("FAIL single_arb: got %b exp 0", bus.arb_idle); end
        tick();
        bus.empty_F = 4'hF;
        n_checks++; if (bus.push_P !== 4'b0010) begin n_fail++; $display("FAIL single_push: got %b exp 0010", bus.push_P); end
        n_checks++; if (bus.data_out !== 6'b01_1010) begin n_fail++; $display("FAIL single_data: got %b exp 011010", bus.data_out); end
        tick();
        n_checks++; if (bus.push_P !== 4'b0000) begin n_fail++; $display("FAIL single_push_end: got %b exp 0000", bus.push_P); end
    endtask

    task automatic test_rr_order;
        logic [5:0] words [4];
        words[0] = 6'h05; words[1] = 6'h0A; words[2] = 6'h0C; words[3] = 6'h0F;
        do_reset();
        bus.enable  = 1'b1;
        bus.empty_F = 4'h0;
        set_data(words[0], words[1], words[2], words[3]);
        tick();
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (bus.pop_F !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_pop[%0d]: got %b exp %b", k, bus.pop_F, 4'(1 << (k % 4))); end
            tick();
            n_checks++; if (bus.push_P !== 4'b0001 || bus.data_out !== words[k % 4]) begin n_fail++; $display("FAIL rr_push[%0d]: got %b/%h exp 0001/%h", k, bus.push_P, bus.data_out, words[k % 4]); end
        end
        bus.enable = 1'b0;
        bus.req    = 1'b1;
        bus.idx    = 2'd0;
        tick();
        bus.req = 1'b0;
        n_checks++; if (bus.valid_contador !== 1'b1 || bus.contador_out !== 5'd8) begin n_fail++; $display("FAIL rr_cnt0: got v=%b c=%0d exp v=1 c=8", bus.valid_contador, bus.contador_out); end
    endtask

    task automatic test_blocked;
        do_reset();
        bus.enable        = 1'b1;
        bus.empty_F       = 4'b1100;
        bus.almost_full_P = 4'b0010;
        set_data(6'b01_0000, 6'b10_0001, 6'd0, 6'd0);
        tick();
        n_checks++; if (bus.pop_F !== 4'b0010) begin n_fail++; $display("FAIL blk_pop: got %b exp 0010", bus.pop_F); end
        tick();
        bus.empty_F = 4'b1110;
        n_checks++; if (bus.push_P !== 4'b0100 || bus.data_out !== 6'b10_0001) begin n_fail++; $display("FAIL blk_push: got %b/%b exp 0100/100001", bus.push_P, bus.data_out); end
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (bus.pop_F !== 4'b0000) begin n_fail++; $display("FAIL blk_hold[%0d]: got %b exp 0000", k, bus.pop_F); end
            tick();
        end
        bus.almost_full_P = 4'b0000;
        #1;
        n_checks++; if (bus.pop_F !== 4'b0001) begin n_fail++; $display("FAIL blk_release: got %b exp 0001", bus.pop_F); end
        tick();
        bus.empty_F = 4'hF;
        n_checks++; if (bus.push_P !== 4'b0010 || bus.data_out !== 6'b01_0000) begin n_fail++; $display("FAIL blk_push2: got %b/%b exp 0010/010000", bus.push_P, bus.data_out); end
    endtask

    task automatic test_wrap_read;
        do_reset();
        bus.enable  = 1'b1;
        bus.empty_F = 4'b0111;
        set_data(6'd0, 6'd0, 6'd0, 6'b11_0101);
        tick();
        for (int k = 1; k <= 32; k++) begin
            if (k == 32) begin
                bus.req = 1'b1;
                bus.idx = 2'd3;
            end
            tick();
            n_checks++; if (bus.push_P !== 4'b1000) begin n_fail++; $display("FAIL wrap_push[%0d]: got %b exp 1000", k, bus.push_P); end
        end
        n_checks++; if (bus.valid_contador !== 1'b1 || bus.contador_out !== 5'd31) begin n_fail++; $display("FAIL wrap_same_edge: got v=%b c=%0d exp v=1 c=31", bus.valid_contador, bus.contador_out); end
        bus.enable = 1'b0;
        tick();
        n_checks++; if (bus.valid_contador !== 1'b1 || bus.contador_out !== 5'd0) begin n_fail++; $display("FAIL wrap_zero: got v=%b c=%0d exp v=1 c=0", bus.valid_contador, bus.contador_out); end
        bus.req = 1'b0;
        tick();
        n_checks++; if (bus.valid_contador !== 1'b0 || bus.contador_out !== 5'd0) begin n_fail++; $display("FAIL wrap_hold: got v=%b c=%0d exp v=0 c=0", bus.valid_contador, bus.contador_out); end
    endtask

    task automatic test_enable_drop;
        do_reset();
        bus.enable  = 1'b1;
        bus.empty_F = 4'b1100;
        set_data(6'b00_0111, 6'b01_0011, 6'd0, 6'd0);
        tick();
        n_checks++; if (bus.pop_F !== 4'b0001) begin n_fail++; $display("FAIL endrop_pop: got %b exp 0001", bus.pop_F); end
        tick();
        bus.enable  = 1'b0;
        bus.empty_F = 4'b1101;
        #1;
        n_checks++; if (bus.push_P !== 4'b0001 || bus.data_out !== 6'b00_0111) begin n_fail++; $display("FAIL endrop_push: got %b/%b exp 0001/000111", bus.push_P, bus.data_out); end
        n_checks++; if (bus.pop_F !== 4'b0000) begin n_fail++; $display("FAIL endrop_nopop: got %b exp 0000", bus.pop_F); end
        tick();
        n_checks++; if (bus.arb_idle !== 1'b1 || bus.push_P !== 4'b0000) begin n_fail++; $display("FAIL endrop_idle: got idle=%b push=%b exp 1/0000", bus.arb_idle, bus.push_P); end
    endtask

    task automatic test_async_reset;
        do_reset();
        bus.enable  = 1'b1;
        bus.empty_F = 4'b1101;
        set_data(6'd0, 6'b10_1110, 6'd0, 6'd0);
        tick();
        n_checks++; if (bus.pop_F !== 4'b0010) begin n_fail++; $display("FAIL areset_pop: got %b exp 0010", bus.pop_F); end
        bus.req = 1'b1;
        tick();
        n_checks++; if (bus.push_P !== 4'b0100 || bus.valid_contador !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got push=%b v=%b exp 0100/1", bus.push_P, bus.valid_contador); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.push_P !== 4'b0000 || bus.data_out !== 6'd0 || bus.pop_F !== 4'b0000) begin n_fail++; $display("FAIL areset_now: got push=%b data=%b pop=%b exp 0", bus.push_P, bus.data_out, bus.pop_F); end
        n_checks++; if (bus.valid_contador !== 1'b0 || bus.arb_idle !== 1'b1) begin n_fail++; $display("FAIL areset_flags: got v=%b idle=%b exp 0/1", bus.valid_contador, bus.arb_idle); end
        tick();
        n_checks++; if (bus.push_P !== 4'b0000) begin n_fail++; $display("FAIL areset_edge: got %b exp 0000", bus.push_P); end
        reset = 1'b0;
        bus.req = 1'b0;
    endtask

    task automatic test_random;
        logic [5:0] d [4];
        logic [3:0] exp_pop;
        logic [3:0] m_push;
        logic [5:0] m_data;
        logic [4:0] m_cout;
        logic       m_valid;
        bit         m_arb;
        int         m_ptr;
        int         m_cnt [4];
        int         pick;
        int         cand;
        int         dst;
        do_reset();
        m_arb = 1'b0; m_ptr = 0; m_push = 4'd0; m_data = 6'd0; m_cout = 5'd0; m_valid = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) d[i] = 6'($urandom);
            set_data(d[0], d[1], d[2], d[3]);
            bus.enable        = ($urandom_range(9, 0) != 0);
            bus.empty_F       = 4'($urandom);
            bus.almost_full_P = 4'($urandom) & 4'($urandom);
            bus.req           = 1'($urandom);
            bus.idx           = 2'($urandom);
            #1;
            pick = -1;
            if (m_arb && bus.enable) begin
                for (int k = 0; k < 4; k++) begin
                    cand = (m_ptr + k) % 4;
                    if (pick < 0 && !bus.empty_F[cand] && !bus.almost_full_P[d[cand][5:4]]) pick = cand;
                end
            end
            exp_pop = (pick < 0) ? 4'd0 : 4'(1 << pick);
            n_checks++; if (bus.pop_F !== exp_pop) begin n_fail++; $display("FAIL rnd_pop[%0d]: got %b exp %b", cyc, bus.pop_F, exp_pop); end
            m_valid = bus.req;
            if (bus.req) m_cout = 5'(m_cnt[bus.idx]);
            if (pick >= 0) begin
                dst         = int'(d[pick][5:4]);
                m_push      = 4'(1 << dst);
                m_data      = d[pick];
                m_ptr       = (pick + 1) % 4;
                m_cnt[dst]  = (m_cnt[dst] + 1) % 32;
            end else begin
                m_push = 4'd0;
            end
            if (!m_arb) m_arb = bus.enable && (bus.empty_F != 4'hF);
            else        m_arb = bus.enable && (bus.empty_F != 4'hF);
            tick();
            n_checks++; if (bus.push_P !== m_push || bus.data_out !== m_data) begin n_fail++; $display("FAIL rnd_push[%0d]: got %b/%h exp %b/%h", cyc, bus.push_P, bus.data_out, m_push, m_data); end
            n_checks++; if (bus.valid_contador !== m_valid || bus.contador_out !== m_cout) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got v=%b c=%0d exp v=%b c=%0d", cyc, bus.valid_contador, bus.contador_out, m_valid, m_cout); end
            n_checks++; if (bus.arb_idle !== !m_arb) begin n_fail++; $display("FAIL rnd_idle[%0d]: got %b exp %b", cyc, bus.arb_idle, !m_arb); end
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_rr_order();
        test_blocked();
        test_wrap_read();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
